uart_rx_mealy: RTL
==================

Name: uart_rx_mealy

Overview:
- Serial UART receiver built as a Mealy FSM with a per-state timer and feedback (recursive) registers.
- Receive-side counterpart of the chapter's serial transmitter. Converts an asynchronous 8N1 line into parallel words with a one-cycle valid strobe.
- Sits between a board RX pin and any byte consumer, e.g. the display or LED demos.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; must be even and at least 4.
- DATA_BITS, 8, data bits per frame (1..16), sent LSB first.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-low reset (reset==0 at a clk rising edge resets the block).
- rx  input  1  asynchronous serial line; idles high.
- rx_data  output  DATA_BITS  last received word; held until the next good frame.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- busy  output  1  high in any state except IDLE.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- parity_err  output  1  one-cycle pulse on parity mismatch; constant 0 without RX_PARITY_EN.

Behaviour:
- Synchronizer: rx passes through a 2-FF synchronizer, giving rx_s with 2 cycles of latency. The FSM sees only rx_s.
- Reset values:
  - state=IDLE, t=0, shift register=0, bit counter=0.
  - rx_data=0, rx_valid=0, busy=0, frame_err=0, parity_err=0.
  - Synchronizer FFs reset to 1.
- Reset mid-frame: all of the above take effect at the next edge. The partial word is discarded and no strobe is issued.
- Timer t:
  - Clears on every state change; otherwise increments.
  - Width is ceil(log2(CLKS_PER_BIT)).
  - In DATA it is also cleared at each sample point.
- Feedback registers: sh_reg (DATA_BITS wide), n_reg (bit index, width ceil(log2(DATA_BITS+1))).
- State IDLE:
  - busy=0.
  - rx_s==0 moves to START.
- State START:
  - Waits until t==CLKS_PER_BIT/2-1 (mid start bit).
  - If rx_s==0 there, go to DATA with n_next=0.
  - If rx_s==1 there, treat it as a glitch and return to IDLE with no outputs.
- State DATA:
  - Each time t==CLKS_PER_BIT-1, sample rx_s: sh_next = {rx_s, sh_reg[DATA_BITS-1:1]} and n_next = n_reg+1.
  - After sample number DATA_BITS, go to PARITY if enabled, else STOP.
- State STOP, at t==CLKS_PER_BIT-1:
  - rx_s==1: load rx_data<=sh_reg, pulse rx_valid, go to IDLE.
  - rx_s==0: pulse frame_err, leave rx_data unchanged, go to BREAK.
- State BREAK:
  - Stays until rx_s==1, then goes to IDLE.
  - A line held low therefore yields exactly one frame_err and no further frames.
- Output registering: rx_valid, frame_err and parity_err come from the Mealy logic and are registered once (glitch-free). They are asserted in the cycle after the sample edge and last exactly 1 cycle.
- Latency: the rx_valid rising edge occurs 2 + CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT + 1 cycles after the rx falling edge, ±1 cycle of synchronizer phase.
- Back-to-back frames: after a good stop bit the FSM reaches IDLE at mid stop bit, so a start bit immediately following is caught with no lost frame.
- Simultaneous events: none possible; each state has at most one sample point per cycle.

Optional Feature:
- Macro RX_PARITY_EN.
- When defined:
  - A PARITY state follows DATA.
  - At t==CLKS_PER_BIT-1 it samples the even-parity bit and compares it with the XOR of sh_reg.
  - On mismatch it raises internal flag perr_reg; the flag clears on entry to START.
  - In STOP with rx_s==1: if perr_reg is set, pulse parity_err and skip rx_valid; otherwise pulse rx_valid.
  - Frame length becomes DATA_BITS+3 bits.
- When undefined: no PARITY state, perr_reg removed, parity_err tied to 0.

Decomposition:
- Package uart_rx_pkg holds:
  - State encoding localparams IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, BREAK=5 on a 3-bit state.
  - A default CLKS_PER_BIT constant.
  - A clog2-based width function.
- One sub-module, sync_2ff: a 1-bit two-flop synchronizer with synchronous active-low reset to 1.

Test Plan:
- Good frame: CLKS_PER_BIT=16, DATA_BITS=8; send 0xA5 8N1 -> rx_data=0xA5, one rx_valid pulse, frame_err=0, busy high for the whole frame.
- Glitch: rx low for 5 cycles, then high -> back to IDLE, no rx_valid, rx_data unchanged.
- Bad stop bit: send 0x3C with stop bit 0, keep rx low for 64 cycles, then release -> exactly one frame_err pulse, no rx_valid, rx_data still 0xA5, busy until rx high + 2.
- Back-to-back: send 0x00 then 0xFF with no idle gap -> two rx_valid pulses, data 0x00 then 0xFF.
- Reset mid-frame: assert reset=0 for 1 cycle during bit 4 of 0x81 -> all outputs 0 next cycle, no strobe; the following frame 0x42 is received correctly.
- RX_PARITY_EN: send 0x07 with parity 1 -> rx_valid with 0x07. Send 0x07 with parity 0 -> parity_err pulse, no rx_valid.

Source files
------------

// File: rtl/uart_rx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_rx_pkg                                                     |
// | Purpose  : Shared state encoding, default bit timing and a width helper    |
// |            for the uart_rx_mealy receiver.                                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package uart_rx_pkg;

  // Receiver states on a 3-bit encoding
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_t;

  localparam int C_DEFAULT_CLKS_PER_BIT = 16;

  // ceil(log2(n)), never below 1 so a counter always has at least one bit
  function automatic int clog2w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sync_2ff                                                        |
// | Purpose  : 1-bit two-flop synchronizer for an asynchronous input.          |
// | Ports    : clk   - system clock                                            |
// |            reset - synchronous active-low reset (flops reset to 1)         |
// |            i_d   - asynchronous input                                      |
// |            o_q   - synchronized output, 2 cycles of latency                |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Reset to 1 so an idle-high line does not look like a start bit
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx_mealy.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_rx_mealy                                                   |
// | Purpose  : 8N1-style UART receiver built as a Mealy FSM with a per-state   |
// |            timer and shift/bit-count feedback registers.                   |
// | Ports    : clk        - system clock                                       |
// |            reset      - synchronous active-low reset                       |
// |            rx         - asynchronous serial line, idles high               |
// |            rx_data    - last good word, held until the next good frame     |
// |            rx_valid   - 1-cycle strobe when rx_data updates                |
// |            busy       - high whenever the FSM is not in IDLE               |
// |            frame_err  - 1-cycle strobe when the stop bit is sampled low    |
// |            parity_err - 1-cycle strobe on even-parity mismatch             |
// | Options  : RX_PARITY_EN - adds an even-parity bit between data and stop;   |
// |            when undefined parity_err is tied to 0.                         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module uart_rx_mealy
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = C_DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 parity_err
);

  localparam int c_TW = clog2w(CLKS_PER_BIT);
  localparam int c_NW = clog2w(DATA_BITS + 1);
  localparam logic [c_TW-1:0] c_T_HALF = c_TW'(CLKS_PER_BIT/2 - 1);
  localparam logic [c_TW-1:0] c_T_FULL = c_TW'(CLKS_PER_BIT - 1);
  localparam logic [c_NW-1:0] c_N_LAST = c_NW'(DATA_BITS - 1);

  logic                 w_rx_s;

  rx_state_t            r_state, w_state_n;
  logic [c_TW-1:0]      r_t,     w_t_n;
  logic [DATA_BITS-1:0] r_sh,    w_sh_n;
  logic [c_NW-1:0]      r_n,     w_n_n;
  logic [DATA_BITS:0]   w_sh_cat;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid, r_frame_err;
  logic                 w_valid, w_ferr, w_load;
`ifdef RX_PARITY_EN
  logic                 r_perr, w_perr_n;
  logic                 r_parity_err, w_perr_pulse;
`endif

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (rx),
    .o_q   (w_rx_s)
  );

  // New bit enters at the MSB so the first (LSB) bit ends up at bit 0
  assign w_sh_cat = {w_rx_s, r_sh};

  always_comb begin
    w_state_n = r_state;
    w_t_n     = r_t + c_TW'(1);
    w_sh_n    = r_sh;
    w_n_n     = r_n;
    w_valid   = 1'b0;
    w_ferr    = 1'b0;
    w_load    = 1'b0;
`ifdef RX_PARITY_EN
    w_perr_n     = r_perr;
    w_perr_pulse = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (!w_rx_s) begin
          w_state_n = START;
`ifdef RX_PARITY_EN
          w_perr_n  = 1'b0;
`endif
        end
      end
      START: begin
        if (r_t == c_T_HALF) begin
          if (!w_rx_s) begin
            w_state_n = DATA;
            w_n_n     = '0;
          end else begin
            w_state_n = IDLE;      // glitch, not a start bit
          end
        end
      end
      DATA: begin
        if (r_t == c_T_FULL) begin
          w_t_n  = '0;
          w_sh_n = w_sh_cat[DATA_BITS:1];
          w_n_n  = r_n + c_NW'(1);
          if (r_n == c_N_LAST) begin
`ifdef RX_PARITY_EN
            w_state_n = PARITY;
`else
            w_state_n = STOP;
`endif
          end
        end
      end
`ifdef RX_PARITY_EN
      PARITY: begin
        if (r_t == c_T_FULL) begin
          if (w_rx_s != (^r_sh)) w_perr_n = 1'b1;
          w_state_n = STOP;
        end
      end
`endif
      STOP: begin
        // Sampled at mid stop bit, so IDLE is reached in time for a
        // start bit that follows immediately
        if (r_t == c_T_FULL) begin
          if (w_rx_s) begin
            w_state_n = IDLE;
`ifdef RX_PARITY_EN
            if (r_perr) begin
              w_perr_pulse = 1'b1;
            end else begin
              w_valid = 1'b1;
              w_load  = 1'b1;
            end
`else
            w_valid = 1'b1;
            w_load  = 1'b1;
`endif
          end else begin
            w_ferr    = 1'b1;
            w_state_n = BREAK;
          end
        end
      end
      BREAK: begin
        if (w_rx_s) w_state_n = IDLE;
      end
      default: w_state_n = IDLE;
    endcase
    if (w_state_n != r_state) w_t_n = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_t         <= '0;
      r_sh        <= '0;
      r_n         <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef RX_PARITY_EN
      r_perr       <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_n;
      r_t         <= w_t_n;
      r_sh        <= w_sh_n;
      r_n         <= w_n_n;
      r_rx_valid  <= w_valid;
      r_frame_err <= w_ferr;
      if (w_load) r_rx_data <= r_sh;
`ifdef RX_PARITY_EN
      r_perr       <= w_perr_n;
      r_parity_err <= w_perr_pulse;
`endif
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign busy      = (r_state != IDLE);
`ifdef RX_PARITY_EN
  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

endmodule
`default_nettype wire
